// File: rtl/msi_dir_pkg.sv
// msi_dir_pkg: MSI directory message encodings, directory states and FSM states
package msi_dir_pkg;
  typedef enum logic [2:0] {
    REQ_READ_MISS  = 3'b001,
    REQ_WRITE_MISS = 3'b010,
    MSG_FETCH      = 3'b011,
    MSG_FETCH_INV  = 3'b100,
    MSG_INV        = 3'b101,
    REQ_WRITE_BACK = 3'b110
  } msg_type_e;
  typedef enum logic [1:0] {
    DIR_UNCACHED  = 2'b00,
    DIR_SHARED    = 2'b01,
    DIR_EXCLUSIVE = 2'b10
  } dir_state_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_SEND_MSG,
    S_SEND_INV,
    S_WAIT_DATA,
    S_RESP
  } fsm_e;
endpackage

// File: rtl/msi_directory_store.sv
// msi_directory_store: per-block directory state, sharer vector and memory data
module msi_directory_store
  import msi_dir_pkg::*;
#(
  parameter int NUM_PROC = 2,
  parameter int AW       = 4,
  parameter int DW       = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [AW-1:0]       i_rd_addr,
  output logic [1:0]          o_rd_state,
  output logic [NUM_PROC-1:0] o_rd_sharers,
  output logic [DW-1:0]       o_rd_data,
  input  logic                i_we,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic [1:0]          i_wr_state,
  input  logic [NUM_PROC-1:0] i_wr_sharers,
  input  logic [DW-1:0]       i_wr_data
);
  logic [1:0]          r_state   [2**AW];
  logic [NUM_PROC-1:0] r_sharers [2**AW];
  logic [DW-1:0]       r_mem     [2**AW];
  assign o_rd_state   = r_state[i_rd_addr];
  assign o_rd_sharers = r_sharers[i_rd_addr];
  assign o_rd_data    = r_mem[i_rd_addr];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 2**AW; i++) begin
        r_state[i]   <= DIR_UNCACHED;
        r_sharers[i] <= '0;
        r_mem[i]     <= '0;
      end
    end else if (i_we) begin
      r_state[i_wr_addr]   <= i_wr_state;
      r_sharers[i_wr_addr] <= i_wr_sharers;
      r_mem[i_wr_addr]     <= i_wr_data;
    end
  end
endmodule

// File: rtl/msi_directory_ctrl.sv
// msi_directory_ctrl: MSI home-node directory FSM issuing fetch/invalidate messages and data replies
module msi_directory_ctrl
  import msi_dir_pkg::*;
#(
  parameter int NUM_PROC = 2,
  parameter int PW       = 1,
  parameter int AW       = 4,
  parameter int DW       = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [PW-1:0]       i_req_proc,
  input  logic [2:0]          i_req_type,
  input  logic [AW-1:0]       i_req_address,
  input  logic [DW-1:0]       i_req_data,
  output logic                o_msg_valid,
  output logic [NUM_PROC-1:0] o_msg_target,
  output logic [2:0]          o_msg_type,
  output logic [AW-1:0]       o_msg_address,
  input  logic                i_fetch_valid,
  input  logic [DW-1:0]       i_fetch_data,
  output logic                o_resp_valid,
  output logic [PW-1:0]       o_resp_proc,
  output logic [DW-1:0]       o_resp_data,
  output logic [AW-1:0]       o_resp_address
);
  fsm_e                r_fsm;
  logic [PW-1:0]       r_proc;
  logic [2:0]          r_type;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_req_data;
  logic [DW-1:0]       r_data;
  logic [1:0]          r_new_state;
  logic [NUM_PROC-1:0] r_new_sharers;
  logic [2:0]          r_pend_msg;
  logic [NUM_PROC-1:0] r_pend_target;
  logic                r_msg_valid;
  logic [NUM_PROC-1:0] r_msg_target;
  logic [2:0]          r_msg_type;
  logic [AW-1:0]       r_msg_address;
  logic                r_resp_valid;
  logic [PW-1:0]       r_resp_proc;
  logic [DW-1:0]       r_resp_data;
  logic [AW-1:0]       r_resp_address;
  logic [1:0]          w_state;
  logic [NUM_PROC-1:0] w_sharers;
  logic [DW-1:0]       w_data;
  logic [NUM_PROC-1:0] w_req_mask;
  logic [NUM_PROC-1:0] w_others;
  logic                w_rd;
  logic                w_wr;
  logic                w_excl;
  logic                w_own;
  logic                w_fetch;
  logic                w_inv;
  logic                w_wb_commit;
  fsm_e                w_lookup_next;
  logic [1:0]          w_pend_state;
  logic [NUM_PROC-1:0] w_pend_sharers;
  logic [2:0]          w_pend_msg;
  logic [NUM_PROC-1:0] w_pend_target;
  logic                w_we;
  logic [1:0]          w_wr_state;
  logic [NUM_PROC-1:0] w_wr_sharers;
  logic [DW-1:0]       w_wr_data;
  always_comb begin
    w_req_mask     = NUM_PROC'(1) << r_proc;
    w_others       = w_sharers & ~w_req_mask;
    w_rd           = r_type == REQ_READ_MISS;
    w_wr           = r_type == REQ_WRITE_MISS;
    w_excl         = w_state == DIR_EXCLUSIVE;
    w_own          = w_excl && w_sharers == w_req_mask;
    w_fetch        = (w_rd || w_wr) && w_excl && !w_own;
    w_inv          = w_wr && w_state == DIR_SHARED && |w_others;
    w_wb_commit    = r_fsm == S_LOOKUP && r_type == REQ_WRITE_BACK && w_own;
    w_lookup_next  = w_fetch ? S_SEND_MSG : w_inv ? S_SEND_INV : (w_rd || w_wr) ? S_RESP : S_IDLE;
    w_pend_state   = w_own ? w_state : w_rd ? DIR_SHARED : DIR_EXCLUSIVE;
    w_pend_sharers = w_own ? w_sharers : w_rd ? (w_sharers | w_req_mask) : w_req_mask;
    w_pend_msg     = w_inv ? MSG_INV : w_rd ? MSG_FETCH : MSG_FETCH_INV;
    w_pend_target  = w_inv ? w_others : w_sharers;
    w_we           = w_wb_commit || r_fsm == S_RESP;
    w_wr_state     = w_wb_commit ? DIR_UNCACHED : r_new_state;
    w_wr_sharers   = w_wb_commit ? '0 : r_new_sharers;
    w_wr_data      = w_wb_commit ? r_req_data : r_data;
  end
  msi_directory_store #(.NUM_PROC(NUM_PROC), .AW(AW), .DW(DW)) u_store (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rd_addr    (r_addr),
    .o_rd_state   (w_state),
    .o_rd_sharers (w_sharers),
    .o_rd_data    (w_data),
    .i_we         (w_we),
    .i_wr_addr    (r_addr),
    .i_wr_state   (w_wr_state),
    .i_wr_sharers (w_wr_sharers),
    .i_wr_data    (w_wr_data)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fsm          <= S_IDLE;
      r_proc         <= '0;
      r_type         <= '0;
      r_addr         <= '0;
      r_req_data     <= '0;
      r_data         <= '0;
      r_new_state    <= DIR_UNCACHED;
      r_new_sharers  <= '0;
      r_pend_msg     <= '0;
      r_pend_target  <= '0;
      r_msg_valid    <= 1'b0;
      r_msg_target   <= '0;
      r_msg_type     <= '0;
      r_msg_address  <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_proc    <= '0;
      r_resp_data    <= '0;
      r_resp_address <= '0;
    end else begin
      r_msg_valid    <= 1'b0;
      r_msg_target   <= '0;
      r_msg_type     <= '0;
      r_msg_address  <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_proc    <= '0;
      r_resp_data    <= '0;
      r_resp_address <= '0;
      case (r_fsm)
        S_IDLE: if (i_req_valid) begin
          r_proc     <= i_req_proc;
          r_type     <= i_req_type;
          r_addr     <= i_req_address;
          r_req_data <= i_req_data;
          r_fsm      <= S_LOOKUP;
        end
        S_LOOKUP: begin
          r_new_state   <= w_pend_state;
          r_new_sharers <= w_pend_sharers;
          r_pend_msg    <= w_pend_msg;
          r_pend_target <= w_pend_target;
          r_data        <= w_data;
          r_fsm         <= w_lookup_next;
        end
        S_SEND_MSG, S_SEND_INV: begin
          r_msg_valid   <= 1'b1;
          r_msg_target  <= r_pend_target;
          r_msg_type    <= r_pend_msg;
          r_msg_address <= r_addr;
          r_fsm         <= r_fsm == S_SEND_MSG ? S_WAIT_DATA : S_RESP;
        end
        S_WAIT_DATA: if (i_fetch_valid) begin
          r_data <= i_fetch_data;
          r_fsm  <= S_RESP;
        end
        S_RESP: begin
          r_resp_valid   <= 1'b1;
          r_resp_proc    <= r_proc;
          r_resp_data    <= r_data;
          r_resp_address <= r_addr;
          r_fsm          <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end
  assign o_req_ready    = r_fsm == S_IDLE;
  assign o_msg_valid    = r_msg_valid;
  assign o_msg_target   = r_msg_target;
  assign o_msg_type     = r_msg_type;
  assign o_msg_address  = r_msg_address;
  assign o_resp_valid   = r_resp_valid;
  assign o_resp_proc    = r_resp_proc;
  assign o_resp_data    = r_resp_data;
  assign o_resp_address = r_resp_address;
endmodule

// File: tb/tb_msi_directory_ctrl.sv
// tb_msi_directory_ctrl: directed scenario checks for the MSI directory controller
module tb_msi_directory_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_proc = 1'b0;
  logic [2:0] req_type = '0;
  logic [3:0] req_address = '0;
  logic [3:0] req_data = '0;
  logic       msg_valid;
  logic [1:0] msg_target;
  logic [2:0] msg_type;
  logic [3:0] msg_address;
  logic       fetch_valid = 1'b0;
  logic [3:0] fetch_data = '0;
  logic       resp_valid;
  logic       resp_proc;
  logic [3:0] resp_data;
  logic [3:0] resp_address;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  msi_directory_ctrl dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_proc     (req_proc),
    .i_req_type     (req_type),
    .i_req_address  (req_address),
    .i_req_data     (req_data),
    .o_msg_valid    (msg_valid),
    .o_msg_target   (msg_target),
    .o_msg_type     (msg_type),
    .o_msg_address  (msg_address),
    .i_fetch_valid  (fetch_valid),
    .i_fetch_data   (fetch_data),
    .o_resp_valid   (resp_valid),
    .o_resp_proc    (resp_proc),
    .o_resp_data    (resp_data),
    .o_resp_address (resp_address)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_req(input logic p, input logic [2:0] t, input logic [3:0] a, input logic [3:0] d);
    req_valid = 1'b1; req_proc = p; req_type = t; req_address = a; req_data = d;
    step();
    req_valid = 1'b0; req_type = '0; req_data = '0;
  endtask
  task automatic wait_msg(output bit ok);
    ok = 0;
    for (int n = 0; n < 8 && !ok; n++) begin
      step();
      ok = msg_valid;
    end
  endtask
  task automatic wait_resp(output bit ok);
    ok = 0;
    for (int n = 0; n < 8 && !ok; n++) begin
      step();
      ok = resp_valid;
    end
  endtask
  task automatic test_reset();
    step(); step();
    rst = 1'b0;
    total++; if ({req_ready, msg_valid, resp_valid} !== 3'b100) begin bad++; $display("FAIL reset_ctrl got=%b want=100", {req_ready, msg_valid, resp_valid}); end
    total++; if ({msg_target, msg_type, msg_address, resp_proc, resp_data, resp_address} !== 22'd0) begin bad++; $display("FAIL reset_fields got=%h want=0", {msg_target, msg_type, msg_address, resp_proc, resp_data, resp_address}); end
  endtask
  task automatic test_read_miss();
    send_req(1'b0, 3'b001, 4'h4, 4'h0);
    step();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rm_early got=%b want=0", resp_valid); end
    step();
    total++; if ({resp_valid, resp_proc, resp_data, resp_address} !== {1'b1, 1'b0, 4'h0, 4'h4}) begin bad++; $display("FAIL rm_resp got=%b want=%b", {resp_valid, resp_proc, resp_data, resp_address}, {1'b1, 1'b0, 4'h0, 4'h4}); end
    total++; if ({dut.u_store.r_state[4], dut.u_store.r_sharers[4]} !== 4'b0101) begin bad++; $display("FAIL rm_entry got=%b want=0101", {dut.u_store.r_state[4], dut.u_store.r_sharers[4]}); end
    total++; if (msg_valid !== 1'b0) begin bad++; $display("FAIL rm_nomsg got=%b want=0", msg_valid); end
    step();
    total++; if ({resp_valid, resp_data, resp_address} !== 9'd0) begin bad++; $display("FAIL rm_pulse got=%h want=0", {resp_valid, resp_data, resp_address}); end
  endtask
  task automatic test_write_inv();
    bit ok;
    send_req(1'b1, 3'b010, 4'h4, 4'h0);
    wait_msg(ok);
    total++; if (!ok || {msg_type, msg_target, msg_address} !== {3'b101, 2'b01, 4'h4}) begin bad++; $display("FAIL wi_msg seen=%0d got=%b want=%b", ok, {msg_type, msg_target, msg_address}, {3'b101, 2'b01, 4'h4}); end
    wait_resp(ok);
    total++; if (!ok || {resp_proc, resp_data, resp_address} !== {1'b1, 4'h0, 4'h4}) begin bad++; $display("FAIL wi_resp seen=%0d got=%b want=%b", ok, {resp_proc, resp_data, resp_address}, {1'b1, 4'h0, 4'h4}); end
    total++; if ({dut.u_store.r_state[4], dut.u_store.r_sharers[4]} !== 4'b1010) begin bad++; $display("FAIL wi_entry got=%b want=1010", {dut.u_store.r_state[4], dut.u_store.r_sharers[4]}); end
  endtask
  task automatic test_fetch();
    bit ok;
    send_req(1'b1, 3'b010, 4'h7, 4'h0);
    wait_resp(ok);
    total++; if (!ok || dut.u_store.r_sharers[7] !== 2'b10) begin bad++; $display("FAIL fe_own seen=%0d got=%b want=10", ok, dut.u_store.r_sharers[7]); end
    send_req(1'b0, 3'b001, 4'h7, 4'h0);
    wait_msg(ok);
    total++; if (!ok || {msg_type, msg_target, msg_address} !== {3'b011, 2'b10, 4'h7}) begin bad++; $display("FAIL fe_msg seen=%0d got=%b want=%b", ok, {msg_type, msg_target, msg_address}, {3'b011, 2'b10, 4'h7}); end
    step();
    total++; if (msg_valid !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL fe_wait got=%b%b want=00", msg_valid, resp_valid); end
    fetch_valid = 1'b1; fetch_data = 4'h6;
    step();
    fetch_valid = 1'b0; fetch_data = 4'h0;
    ok = resp_valid;
    if (!ok) wait_resp(ok);
    total++; if (!ok || {resp_proc, resp_data, resp_address} !== {1'b0, 4'h6, 4'h7}) begin bad++; $display("FAIL fe_resp seen=%0d got=%b want=%b", ok, {resp_proc, resp_data, resp_address}, {1'b0, 4'h6, 4'h7}); end
    total++; if ({dut.u_store.r_state[7], dut.u_store.r_sharers[7], dut.u_store.r_mem[7]} !== 8'b0111_0110) begin bad++; $display("FAIL fe_entry got=%b want=01110110", {dut.u_store.r_state[7], dut.u_store.r_sharers[7], dut.u_store.r_mem[7]}); end
  endtask
  task automatic test_fetch_inv();
    bit ok;
    send_req(1'b1, 3'b010, 4'h7, 4'h0);
    wait_msg(ok);
    total++; if (!ok || {msg_type, msg_target} !== {3'b101, 2'b01}) begin bad++; $display("FAIL fi_inv seen=%0d got=%b want=10101", ok, {msg_type, msg_target}); end
    wait_resp(ok);
    total++; if (!ok || resp_data !== 4'h6) begin bad++; $display("FAIL fi_upg seen=%0d got=%h want=6", ok, resp_data); end
    send_req(1'b0, 3'b010, 4'h7, 4'h0);
    wait_msg(ok);
    total++; if (!ok || {msg_type, msg_target, msg_address} !== {3'b100, 2'b10, 4'h7}) begin bad++; $display("FAIL fi_msg seen=%0d got=%b want=%b", ok, {msg_type, msg_target, msg_address}, {3'b100, 2'b10, 4'h7}); end
    fetch_valid = 1'b1; fetch_data = 4'h3;
    step();
    fetch_valid = 1'b0; fetch_data = 4'h0;
    ok = resp_valid;
    if (!ok) wait_resp(ok);
    total++; if (!ok || {resp_proc, resp_data} !== {1'b0, 4'h3}) begin bad++; $display("FAIL fi_resp seen=%0d got=%b want=00011", ok, {resp_proc, resp_data}); end
    total++; if ({dut.u_store.r_state[7], dut.u_store.r_sharers[7], dut.u_store.r_mem[7]} !== 8'b1001_0011) begin bad++; $display("FAIL fi_entry got=%b want=10010011", {dut.u_store.r_state[7], dut.u_store.r_sharers[7], dut.u_store.r_mem[7]}); end
  endtask
  task automatic test_owner_hit();
    bit ok;
    bit msg_seen = 0;
    send_req(1'b0, 3'b001, 4'h7, 4'h0);
    step(); msg_seen = msg_seen | msg_valid;
    step(); msg_seen = msg_seen | msg_valid;
    total++; if (msg_seen || {resp_valid, resp_data} !== {1'b1, 4'h3}) begin bad++; $display("FAIL oh_resp msg=%0d got=%b want=10011", msg_seen, {resp_valid, resp_data}); end
    total++; if ({dut.u_store.r_state[7], dut.u_store.r_sharers[7]} !== 4'b1001) begin bad++; $display("FAIL oh_entry got=%b want=1001", {dut.u_store.r_state[7], dut.u_store.r_sharers[7]}); end
    ok = 1;
  endtask
  task automatic test_write_back();
    bit ok;
    bit seen = 0;
    send_req(1'b0, 3'b010, 4'h2, 4'h0);
    wait_resp(ok);
    send_req(1'b0, 3'b110, 4'h2, 4'h9);
    for (int n = 0; n < 4; n++) begin step(); seen = seen | resp_valid | msg_valid; end
    total++; if (seen || req_ready !== 1'b1) begin bad++; $display("FAIL wb_quiet out=%0d ready=%b want=0/1", seen, req_ready); end
    total++; if ({dut.u_store.r_state[2], dut.u_store.r_sharers[2], dut.u_store.r_mem[2]} !== 8'b0000_1001) begin bad++; $display("FAIL wb_entry got=%b want=00001001", {dut.u_store.r_state[2], dut.u_store.r_sharers[2], dut.u_store.r_mem[2]}); end
    send_req(1'b1, 3'b001, 4'h2, 4'h0);
    wait_resp(ok);
    total++; if (!ok || {resp_proc, resp_data} !== {1'b1, 4'h9}) begin bad++; $display("FAIL wb_read seen=%0d got=%b want=11001", ok, {resp_proc, resp_data}); end
    send_req(1'b0, 3'b110, 4'h2, 4'h5);
    seen = 0;
    for (int n = 0; n < 4; n++) begin step(); seen = seen | resp_valid | msg_valid; end
    total++; if (seen || {dut.u_store.r_state[2], dut.u_store.r_sharers[2], dut.u_store.r_mem[2]} !== 8'b0110_1001) begin bad++; $display("FAIL wb_drop out=%0d got=%b want=01101001", seen, {dut.u_store.r_state[2], dut.u_store.r_sharers[2], dut.u_store.r_mem[2]}); end
  endtask
  task automatic test_unknown();
    bit seen = 0;
    send_req(1'b1, 3'b111, 4'h5, 4'hf);
    for (int n = 0; n < 4; n++) begin step(); seen = seen | resp_valid | msg_valid; end
    total++; if (seen || req_ready !== 1'b1 || dut.u_store.r_state[5] !== 2'b00) begin bad++; $display("FAIL unk out=%0d ready=%b state=%b want=0/1/00", seen, req_ready, dut.u_store.r_state[5]); end
  endtask
  task automatic test_reset_abort();
    bit ok;
    bit seen = 0;
    int dirty = 0;
    send_req(1'b1, 3'b001, 4'h7, 4'h0);
    wait_msg(ok);
    total++; if (!ok || {msg_type, msg_target} !== {3'b011, 2'b01}) begin bad++; $display("FAIL ra_msg seen=%0d got=%b want=01101", ok, {msg_type, msg_target}); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if ({req_ready, resp_valid} !== 2'b10) begin bad++; $display("FAIL ra_ready got=%b want=10", {req_ready, resp_valid}); end
    fetch_valid = 1'b1; fetch_data = 4'ha;
    step();
    fetch_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin step(); seen = seen | resp_valid; end
    total++; if (seen) begin bad++; $display("FAIL ra_noresp got=1 want=0"); end
    for (int i = 0; i < 16; i++) if (dut.u_store.r_state[i] !== 2'b00 || dut.u_store.r_sharers[i] !== 2'b00 || dut.u_store.r_mem[i] !== 4'h0) dirty++;
    total++; if (dirty != 0) begin bad++; $display("FAIL ra_clear got=%0d dirty entries want=0", dirty); end
    send_req(1'b0, 3'b001, 4'h7, 4'h0);
    wait_resp(ok);
    total++; if (!ok || resp_data !== 4'h0) begin bad++; $display("FAIL ra_read seen=%0d got=%h want=0", ok, resp_data); end
  endtask
  initial begin
    test_reset();
    test_read_miss();
    test_write_inv();
    test_fetch();
    test_fetch_inv();
    test_owner_hit();
    test_write_back();
    test_unknown();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
